// File: rtl/trigger_sequencer.sv
// trigger_sequencer: multi-level advanced-trigger state machine.
// Counts comparator hits per level and walks through up to eight programmable levels.
// It drives the trigger timer's start/clear/stop controls, qualified by an update strobe.
// It takes timeout branches on the timer's elapsed flag and emits a one-cycle capture fire pulse.

module trigger_sequencer #(
  parameter int NUM_LEVELS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wrenb,
  input  logic [2:0]  wraddr,
  input  logic [31:0] config_data,
  input  logic        arm,
  input  logic        disarm,
  input  logic        match_hit,
  input  logic        timer_elapsed,
  output logic        update_timers,
  output logic        fsm_start_timer,
  output logic        fsm_clear_timer,
  output logic        fsm_stop_timer,
  output logic        trigger_fire,
  output logic        armed,
  output logic [2:0]  level
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  // Only the low 25 bits of a config word carry meaning; the rest are reserved.
  localparam int CFG_W = 25;

  logic [CFG_W-1:0] r_cfg [NUM_LEVELS];

  state_t      r_state;
  logic [15:0] r_occ;
  logic [2:0]  r_level;
  logic        r_elapsed_d;
  logic        r_update;
  logic        r_start;
  logic        r_clear;
  logic        r_stop;
  logic        r_fire;
  logic        r_armed;

  logic [CFG_W-1:0] w_cur_cfg;
  logic [15:0]      w_count_n;
  logic             w_cfg_start;
  logic             w_cfg_clear;
  logic             w_cfg_stop;
  logic             w_cfg_fire;
  logic [2:0]       w_else_level;
  logic             w_elapse_en;
  logic             w_elapse_fire;
  logic [15:0]      w_target;
  logic [16:0]      w_occ_inc;
  logic [15:0]      w_occ_sat;
  logic             w_complete;
  logic             w_elapse_event;
  logic [2:0]       w_level_next;
  logic             w_unused;

  // Reserved config bits are accepted but ignored.
  assign w_unused = ^config_data[31:CFG_W];

  // Config storage: any level may be rewritten in any state; the new word is used from the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        r_cfg[i] <= '0;
      end
    end else if (wrenb) begin
      r_cfg[wraddr] <= config_data[CFG_W-1:0];
    end
  end

  // Split the active level's config word into its fields.
  always_comb begin
    w_cur_cfg     = r_cfg[r_level];
    w_count_n     = w_cur_cfg[15:0];
    w_cfg_start   = w_cur_cfg[16];
    w_cfg_clear   = w_cur_cfg[17];
    w_cfg_stop    = w_cur_cfg[18];
    w_cfg_fire    = w_cur_cfg[19];
    w_else_level  = w_cur_cfg[22:20];
    w_elapse_en   = w_cur_cfg[23];
    w_elapse_fire = w_cur_cfg[24];
  end

  // Hit-count compare: an occurrence count of zero behaves like one, so the first hit completes.
  always_comb begin
    w_target   = (w_count_n == 16'd0) ? 16'd1 : w_count_n;
    w_occ_inc  = {1'b0, r_occ} + 17'd1;
    w_occ_sat  = (r_occ == 16'hFFFF) ? 16'hFFFF : w_occ_inc[15:0];
    w_complete = match_hit && (w_occ_inc >= {1'b0, w_target});
  end

  // Completion advances one level, but level 7 is terminal and simply re-arms itself.
  always_comb begin
    w_level_next = (r_level == 3'd7) ? 3'd7 : (r_level + 3'd1);
  end

  // Timeout branches fire on the rising edge of the timer's level-style elapsed flag.
  always_comb begin
    w_elapse_event = timer_elapsed && !r_elapsed_d;
  end

  // Registered copy of timer_elapsed, tracked in every state so a stale high level never looks like a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_elapsed_d <= 1'b0;
    end else begin
      r_elapsed_d <= timer_elapsed;
    end
  end

  // Sequencer FSM: all strobes default low each cycle so every event yields exactly one-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_occ    <= '0;
      r_level  <= '0;
      r_update <= 1'b0;
      r_start  <= 1'b0;
      r_clear  <= 1'b0;
      r_stop   <= 1'b0;
      r_fire   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_start  <= 1'b0;
      r_clear  <= 1'b0;
      r_stop   <= 1'b0;
      r_fire   <= 1'b0;

      if (disarm) begin
        r_state <= ST_IDLE;
        r_armed <= 1'b0;
      end else if (arm) begin
        r_state  <= ST_RUN;
        r_armed  <= 1'b1;
        r_level  <= 3'd0;
        r_occ    <= 16'd0;
        r_update <= 1'b1;
        r_clear  <= 1'b1;
        r_stop   <= 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_elapse_event && w_elapse_en) begin
              r_update <= 1'b1;
              r_clear  <= 1'b1;
              r_stop   <= 1'b1;
              r_occ    <= 16'd0;
              if (w_elapse_fire) begin
                r_fire  <= 1'b1;
                r_state <= ST_FIRED;
                r_armed <= 1'b0;
              end else begin
                r_level <= w_else_level;
              end
            end else if (w_complete) begin
              r_update <= 1'b1;
              r_start  <= w_cfg_start;
              r_clear  <= w_cfg_clear;
              r_stop   <= w_cfg_stop;
              r_occ    <= 16'd0;
              if (w_cfg_fire) begin
                r_fire  <= 1'b1;
                r_state <= ST_FIRED;
                r_armed <= 1'b0;
              end else begin
                r_level <= w_level_next;
              end
            end else if (match_hit) begin
              r_occ <= w_occ_sat;
            end
          end
          ST_FIRED: begin
            r_state <= ST_FIRED;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign update_timers   = r_update;
  assign fsm_start_timer = r_start;
  assign fsm_clear_timer = r_clear;
  assign fsm_stop_timer  = r_stop;
  assign trigger_fire    = r_fire;
  assign armed           = r_armed;
  assign level           = r_level;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed testbench for trigger_sequencer.
// Each scenario task drives stimulus and checks the packed output vector
// {update, start, clear, stop, fire, armed, level[2:0]} against hand-computed values.

module tb_trigger_sequencer;

  logic        clk;
  logic        resetN;
  logic        wrEnb;
  logic [2:0]  wrAddr;
  logic [31:0] configData;
  logic        armIn;
  logic        disarmIn;
  logic        matchHit;
  logic        timerElapsed;
  logic        updateTimers;
  logic        startTimer;
  logic        clearTimer;
  logic        stopTimer;
  logic        triggerFire;
  logic        armedOut;
  logic [2:0]  levelOut;

  logic [8:0]  obs;
  logic [8:0]  expV;
  int          testCount;
  int          failCount;

  trigger_sequencer #(.NUM_LEVELS(8)) dut (
    .clk             (clk),
    .reset_n         (resetN),
    .wrenb           (wrEnb),
    .wraddr          (wrAddr),
    .config_data     (configData),
    .arm             (armIn),
    .disarm          (disarmIn),
    .match_hit       (matchHit),
    .timer_elapsed   (timerElapsed),
    .update_timers   (updateTimers),
    .fsm_start_timer (startTimer),
    .fsm_clear_timer (clearTimer),
    .fsm_stop_timer  (stopTimer),
    .trigger_fire    (triggerFire),
    .armed           (armedOut),
    .level           (levelOut)
  );

  assign obs = {updateTimers, startTimer, clearTimer, stopTimer, triggerFire, armedOut, levelOut};

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the rising edge, where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one level's config word.
  task automatic applyConfig(input logic [2:0] addr, input logic [31:0] data);
    wrEnb      = 1'b1;
    wrAddr     = addr;
    configData = data;
    tick();
    wrEnb      = 1'b0;
  endtask

  // One-cycle arm pulse; outputs afterwards reflect the arm response.
  task automatic applyArm();
    armIn = 1'b1;
    tick();
    armIn = 1'b0;
  endtask

  // Outputs stay zero while reset is held and just after release.
  task automatic test_reset();
    tick();
    expV = 9'b0_0_0_0_0_0_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL reset_hold: got %b expected %b", obs, expV);
    end
    tick();
    resetN = 1'b1;
    tick();
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL reset_release: got %b expected %b", obs, expV);
    end
  endtask

  // Arm produces a clear/stop strobe and armed the following cycle, then the strobe drops.
  task automatic test_arm();
    applyArm();
    expV = 9'b1_0_1_1_0_1_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL arm_strobe: got %b expected %b", obs, expV);
    end
    tick();
    expV = 9'b0_0_0_0_0_1_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL arm_strobe_one_cycle: got %b expected %b", obs, expV);
    end
  endtask

  // Level 0 counts three hits then starts the timer; level 1 fires on its first hit.
  task automatic test_count_fire();
    applyConfig(3'd0, 32'h0001_0003);
    applyConfig(3'd1, 32'h0008_0001);
    applyArm();
    expV = 9'b1_0_1_1_0_1_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL count_arm: got %b expected %b", obs, expV);
    end
    matchHit = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      expV = 9'b0_0_0_0_0_1_000;
      testCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL count_hit%0d: got %b expected %b", i, obs, expV);
      end
    end
    tick();
    expV = 9'b1_1_0_0_0_1_001;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL count_complete_l0: got %b expected %b", obs, expV);
    end
    tick();
    expV = 9'b1_0_0_0_1_0_001;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL count_fire_l1: got %b expected %b", obs, expV);
    end
    tick();
    expV = 9'b0_0_0_0_0_0_001;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL count_fired_quiet: got %b expected %b", obs, expV);
    end
    matchHit = 1'b0;
  endtask

  // Holding timer_elapsed high gives exactly one jump to the else-level.
  task automatic test_elapse_hold();
    applyConfig(3'd0, 32'h00D0_0000);
    applyArm();
    timerElapsed = 1'b1;
    tick();
    expV = 9'b1_0_1_1_0_1_101;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL elapse_jump: got %b expected %b", obs, expV);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      expV = 9'b0_0_0_0_0_1_101;
      testCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL elapse_hold_cycle%0d: got %b expected %b", i, obs, expV);
      end
    end
    timerElapsed = 1'b0;
  endtask

  // Elapse-fire and a completing hit in the same cycle: the elapse response wins.
  task automatic test_elapse_vs_hit();
    applyConfig(3'd0, 32'h0180_0001);
    applyArm();
    matchHit     = 1'b1;
    timerElapsed = 1'b1;
    tick();
    matchHit     = 1'b0;
    expV = 9'b1_0_1_1_1_0_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL elapse_wins: got %b expected %b", obs, expV);
    end
    tick();
    expV = 9'b0_0_0_0_0_0_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL elapse_wins_quiet: got %b expected %b", obs, expV);
    end
    timerElapsed = 1'b0;
  endtask

  // Level 7 with N=2 re-arms itself on each completion; disarm beats a simultaneous arm.
  task automatic test_level7_saturate();
    applyConfig(3'd0, 32'h00F0_0000);
    applyConfig(3'd7, 32'h0000_0002);
    applyArm();
    timerElapsed = 1'b1;
    tick();
    expV = 9'b1_0_1_1_0_1_111;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL l7_enter: got %b expected %b", obs, expV);
    end
    timerElapsed = 1'b0;
    matchHit     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expV = (i % 2 == 1) ? 9'b1_0_0_0_0_1_111 : 9'b0_0_0_0_0_1_111;
      testCount++;
      if (obs !== expV) begin
        failCount++;
        $display("[TB] FAIL l7_hit%0d: got %b expected %b", i, obs, expV);
      end
    end
    matchHit = 1'b0;
    disarmIn = 1'b1;
    armIn    = 1'b1;
    tick();
    disarmIn = 1'b0;
    armIn    = 1'b0;
    expV = 9'b0_0_0_0_0_0_111;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL disarm_priority: got %b expected %b", obs, expV);
    end
    matchHit = 1'b1;
    tick();
    matchHit = 1'b0;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL idle_ignores_hit: got %b expected %b", obs, expV);
    end
  endtask

  // Asynchronous reset mid-sequence clears outputs at once and wipes the config registers.
  task automatic test_async_reset();
    applyConfig(3'd0, 32'h00B0_0004);
    applyConfig(3'd3, 32'h0000_000A);
    applyArm();
    timerElapsed = 1'b1;
    tick();
    expV = 9'b1_0_1_1_0_1_011;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL rst_reach_l3: got %b expected %b", obs, expV);
    end
    timerElapsed = 1'b0;
    matchHit     = 1'b1;
    repeat (5) tick();
    matchHit = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    expV = 9'b0_0_0_0_0_0_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL rst_immediate: got %b expected %b", obs, expV);
    end
    tick();
    resetN = 1'b1;
    tick();
    applyArm();
    expV = 9'b1_0_1_1_0_1_000;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL rst_rearm: got %b expected %b", obs, expV);
    end
    matchHit = 1'b1;
    tick();
    matchHit = 1'b0;
    expV = 9'b1_0_0_0_0_1_001;
    testCount++;
    if (obs !== expV) begin
      failCount++;
      $display("[TB] FAIL rst_cfg_cleared: got %b expected %b", obs, expV);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    testCount    = 0;
    failCount    = 0;
    resetN       = 1'b0;
    wrEnb        = 1'b0;
    wrAddr       = 3'd0;
    configData   = 32'd0;
    armIn        = 1'b0;
    disarmIn     = 1'b0;
    matchHit     = 1'b0;
    timerElapsed = 1'b0;

    test_reset();
    test_arm();
    test_count_fire();
    test_elapse_hold();
    test_elapse_vs_hit();
    test_level7_saturate();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Multi-level advanced-trigger state machine that sits directly upstream of the 36-bit trigger timer. It counts match hits from the trigger comparators, walks through up to 8 programmable levels, and issues the timer's start/clear/stop controls with an `update_timers` strobe. It consumes the timer's `timer_elapsed` output to take timeout branches, and asserts a one-cycle fire pulse toward the capture controller.

## Interface
- `NUM_LEVELS`, 8: number of trigger levels. Fixed at 8; the level index is 3 bits.
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `wrenb` input 1: config write strobe.
- `wraddr` input 3: level number being written.
- `config_data` input 32: level config word.
- `arm` input 1: one-cycle pulse; (re)starts the sequence at level 0.
- `disarm` input 1: one-cycle pulse; returns the block to IDLE.
- `match_hit` input 1: comparator hit, qualified by the sample strobe upstream.
- `timer_elapsed` input 1: level output from the timer.
- `update_timers` output 1: one-cycle strobe qualifying the three controls below.
- `fsm_start_timer` output 1: timer start control.
- `fsm_clear_timer` output 1: timer clear control.
- `fsm_stop_timer` output 1: timer stop control.
- `trigger_fire` output 1: one-cycle capture-trigger pulse.
- `armed` output 1: high while in state RUN.
- `level` output 3: current level.

## Operation
- Config word per level, written when `wrenb` is high to `cfg[wraddr]`:
  - `[15:0]` occurrence count N. N=0 is treated as 1.
  - `[16]` start timer on completion.
  - `[17]` clear timer on completion.
  - `[18]` stop timer on completion.
  - `[19]` fire on completion.
  - `[22:20]` else-level.
  - `[23]` elapse enable.
  - `[24]` elapse fires instead of jumping.
- Writes are legal in any state and take effect from the next cycle. All `cfg` registers reset to 0.
- States:
  - IDLE → RUN on `arm`.
  - RUN → FIRED on any fire.
  - RUN, FIRED → IDLE on `disarm`.
  - FIRED → RUN on `arm`.
  - `arm` while in RUN restarts at level 0.
  - `disarm` has priority over `arm`.
- On `arm`: `level`=0 and `occ`=0. Issue `update_timers` with clear=1, stop=1, start=0.
- Hit counting (RUN only): each `match_hit` cycle increments the 16-bit `occ`. Completion occurs on the hit where `occ`+1 ≥ max(N,1).
- Completion:
  - Emit `update_timers` with the level's start/clear/stop bits. Zero bits still strobe.
  - `occ` returns to 0.
  - If fire=1: `trigger_fire` and go to FIRED.
  - Otherwise `level` becomes `level`+1, saturating at 7. At level 7, completion without fire re-arms level 7 with `occ`=0.
- Elapse event is the rising edge of `timer_elapsed`, detected with a registered copy. The copy is reset to 0 and updated in all states. An event counts only in RUN with elapse enable=1:
  - If elapse-fire=1: fire and go to FIRED.
  - Otherwise `level` becomes else-level and `occ`=0.
  - In both cases emit `update_timers` with clear=1, stop=1.
- Elapse event and completion in the same cycle: the elapse event wins and the hit is discarded.
- No hits are counted in IDLE or FIRED. `match_hit` in the same cycle as `arm` is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE; `level`=0; `occ`=0.
- `reset_n` assertion clears everything immediately, mid-sequence included. Pending pulses are dropped.
- Latency:
  - Completing hit at cycle T → `update_timers`, controls, `trigger_fire` and new `level` all visible at T+1.
  - `timer_elapsed` rising at T → response at T+1.
  - `arm` at T → `armed`=1 and the clear/stop strobe at T+1.
- `update_timers` and `trigger_fire` are high for exactly one cycle per event. The control bits are 0 whenever `update_timers` is 0.
- `armed` drops the cycle after fire/`disarm` (same cycle as `trigger_fire`).
- `occ` saturates at 0xFFFF. It cannot wrap, since completion occurs at or before N ≤ 0xFFFF.

## Test plan
- Reset, then `arm`: at T+1 `update_timers`=1, clear=1, stop=1, start=0, `armed`=1, `level`=0. All outputs stay 0 during reset.
- Level 0: N=3, start=1. Level 1: N=1, fire=1. Three hits → start strobe one cycle after the 3rd hit, `level`=1. One more hit → `trigger_fire` pulse, `armed`=0. Further hits → no outputs.
- Level 0: N=0, elapse enable=1, else-level=5. Drive `timer_elapsed` high and hold it 10 cycles → exactly one jump to level 5 with a clear/stop strobe; `occ`=0.
- Level 0: N=1, elapse enable=1, elapse-fire=1. Hit and `timer_elapsed` rising in the same cycle → `trigger_fire`, with clear=1, stop=1 and start=0 (completion ignored).
- Level 7: N=2, fire=0. Four hits → two completion strobes and `level` stays 7. Then `disarm` together with `arm` → IDLE, `armed`=0.
- Mid-sequence (`level`=3, `occ`=5): pulse `reset_n` low asynchronously → outputs and `level` are 0 immediately. The `cfg` registers are cleared, so a re-arm with N=0 completes on the first hit.
